// File: rtl/datapath_pkg.sv
// datapath_pkg: shared widths and ALU function codes for the register-file
// datapath. Imported by the interface, the register file and the top.
package datapath_pkg;

    localparam int DATA_W   = 8;
    localparam int ADDR_W   = 4;
    localparam int NUM_REGS = 16;

    typedef enum logic [3:0] {
        OP_ZERO  = 4'b0000,
        OP_A     = 4'b0001,
        OP_B     = 4'b0010,
        OP_NOT   = 4'b0011,
        OP_ADD   = 4'b0100,
        OP_NEG   = 4'b0101,
        OP_AND   = 4'b0110,
        OP_OR    = 4'b0111,
        OP_EQ    = 4'b1000,
        OP_GT    = 4'b1001,
        OP_LT    = 4'b1010,
        OP_SUB   = 4'b1011,
        OP_XOR   = 4'b1100,
        OP_SHL   = 4'b1101,
        OP_SHR   = 4'b1110,
        OP_ZERO2 = 4'b1111
    } aluOp_t;

endpackage

// File: rtl/datapath_if.sv
// datapath_if: per-cycle control/data bundle between a controller and the
// datapath.
//   writeEnable, muxSel, inputData, dstSel, A_sel, B_sel, OP_Sel : controller -> datapath
//   aluOut                                                        : datapath -> controller
// master = controller side, slave = datapath side.
interface datapath_if;
    import datapath_pkg::*;

    logic              writeEnable;
    logic              muxSel;
    logic [DATA_W-1:0] inputData;
    logic [ADDR_W-1:0] dstSel;
    logic [ADDR_W-1:0] A_sel;
    logic [ADDR_W-1:0] B_sel;
    logic [3:0]        OP_Sel;
    logic [DATA_W-1:0] aluOut;

    modport master (
        output writeEnable, muxSel, inputData, dstSel, A_sel, B_sel, OP_Sel,
        input  aluOut
    );

    modport slave (
        input  writeEnable, muxSel, inputData, dstSel, A_sel, B_sel, OP_Sel,
        output aluOut
    );

endinterface

// File: rtl/datapath_register_file.sv
// register_file: sixteen 8-bit registers, two asynchronous read ports and
// one synchronous write port.
//   clk, reset   : rising-edge clock, synchronous active-high clear
//   writeEnable  : store writeData into regs[dstSel] at the edge
//   dstSel       : write index
//   aSel, bSel   : read indices
//   writeData    : write value
//   aData, bData : read values (pre-edge contents during a write)
module register_file
    import datapath_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              writeEnable,
    input  logic [ADDR_W-1:0] dstSel,
    input  logic [ADDR_W-1:0] aSel,
    input  logic [ADDR_W-1:0] bSel,
    input  logic [DATA_W-1:0] writeData,
    output logic [DATA_W-1:0] aData,
    output logic [DATA_W-1:0] bData
);

    logic [DATA_W-1:0] regs [0:NUM_REGS-1];

    // Reset wins over a simultaneous write; dstSel is only looked at when
    // writeEnable is high, so unknown selects on idle cycles leave state alone.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (writeEnable) begin
            regs[dstSel] <= writeData;
        end
    end

    assign aData = regs[aSel];
    assign bData = regs[bSel];

endmodule

// File: rtl/datapath.sv
// datapath: single-cycle execution core. Register file + combinational
// 16-function ALU + write-back mux; no internal control state.
//   clk, reset : rising-edge clock, synchronous active-high clear
//   bus        : datapath_if.slave carrying selects, op, write enable,
//                external data and the observable aluOut (0 during reset)
module datapath
    import datapath_pkg::*;
(
    input  logic     clk,
    input  logic     reset,
    datapath_if.slave bus
);

    logic [DATA_W-1:0] aData;
    logic [DATA_W-1:0] bData;
    logic [DATA_W-1:0] aluResult;
    logic [DATA_W-1:0] writeData;

    register_file regFile (
        .clk         (clk),
        .reset       (reset),
        .writeEnable (bus.writeEnable),
        .dstSel      (bus.dstSel),
        .aSel        (bus.A_sel),
        .bSel        (bus.B_sel),
        .writeData   (writeData),
        .aData       (aData),
        .bData       (bData)
    );

    always_comb begin
        aluResult = '0;
        case (aluOp_t'(bus.OP_Sel))
            OP_ZERO:  aluResult = '0;
            OP_A:     aluResult = aData;
            OP_B:     aluResult = bData;
            OP_NOT:   aluResult = ~aData;
            OP_ADD:   aluResult = aData + bData;
            OP_NEG:   aluResult = (~aData) + 8'd1;
            OP_AND:   aluResult = aData & bData;
            OP_OR:    aluResult = aData | bData;
            OP_EQ:    aluResult = {{(DATA_W-1){1'b0}}, aData == bData};
            OP_GT:    aluResult = {{(DATA_W-1){1'b0}}, aData > bData};
            OP_LT:    aluResult = {{(DATA_W-1){1'b0}}, aData < bData};
            OP_SUB:   aluResult = aData - bData;
            OP_XOR:   aluResult = aData ^ bData;
            OP_SHL:   aluResult = aData << 1;
            OP_SHR:   aluResult = aData >> 1;
            OP_ZERO2: aluResult = '0;
            default:  aluResult = '0;
        endcase
    end

    assign writeData  = bus.muxSel ? bus.inputData : aluResult;
    assign bus.aluOut = reset ? '0 : aluResult;

endmodule

// File: tb/tb_datapath.sv
// tb_datapath: directed self-checking bench for datapath. Expected aluOut
// values are pushed to a scoreboard queue as each step is driven and popped
// when the output settles; register contents are checked through
// uut.regFile.regs against a bench-side model and against fixed constants.
module tb_datapath;

    logic clk;
    logic reset;
    datapath_if bus ();

    datapath uut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned compared   = 0;
    int unsigned mismatched = 0;

    logic [7:0] model [0:15];
    logic [7:0] expQ [$];

    function automatic logic [7:0] refAlu(input logic [3:0] op,
                                          input logic [7:0] a,
                                          input logic [7:0] b);
        logic [8:0] wide;
        case (op)
            4'd0:  return 8'h00;
            4'd1:  return a;
            4'd2:  return b;
            4'd3:  return 8'hFF ^ a;
            4'd4:  begin wide = {1'b0, a} + {1'b0, b}; return wide[7:0]; end
            4'd5:  begin wide = 9'd256 - {1'b0, a}; return wide[7:0]; end
            4'd6:  return a & b;
            4'd7:  return a | b;
            4'd8:  return (a == b) ? 8'd1 : 8'd0;
            4'd9:  return (a > b) ? 8'd1 : 8'd0;
            4'd10: return (a < b) ? 8'd1 : 8'd0;
            4'd11: begin wide = {1'b0, a} + 9'd256 - {1'b0, b}; return wide[7:0]; end
            4'd12: return a ^ b;
            4'd13: return {a[6:0], 1'b0};
            4'd14: return {1'b0, a[7:1]};
            default: return 8'h00;
        endcase
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic checkReg(input int idx, input logic [7:0] exp);
        check($sformatf("r%0d", idx), uut.regFile.regs[idx], exp);
    endtask

    task automatic checkAll(input string tag);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("%s r%0d", tag, i), uut.regFile.regs[i], model[i]);
        end
    endtask

    // One cycle: drive on the falling edge, check aluOut before the rising
    // edge, then update the model and check the destination after it.
    task automatic step(input logic r, input logic we, input logic mux,
                        input logic [7:0] d, input logic [3:0] dst,
                        input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] op);
        logic [7:0] expAlu;
        @(negedge clk);
        reset           = r;
        bus.writeEnable = we;
        bus.muxSel      = mux;
        bus.inputData   = d;
        bus.dstSel      = dst;
        bus.A_sel       = a;
        bus.B_sel       = b;
        bus.OP_Sel      = op;
        expAlu = r ? 8'h00 : refAlu(op, model[a], model[b]);
        expQ.push_back(expAlu);
        #1;
        check($sformatf("aluOut op%0d", op), bus.aluOut, expQ.pop_front());
        @(posedge clk);
        #1;
        if (r) begin
            for (int i = 0; i < 16; i++) model[i] = 8'h00;
        end else if (we) begin
            model[dst] = mux ? d : expAlu;
            check($sformatf("wb r%0d", dst), uut.regFile.regs[dst], model[dst]);
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) model[i] = 8'h00;
        reset           = 1'b1;
        bus.writeEnable = 1'b0;
        bus.muxSel      = 1'b0;
        bus.inputData   = 8'h00;
        bus.dstSel      = 4'd0;
        bus.A_sel       = 4'd0;
        bus.B_sel       = 4'd0;
        bus.OP_Sel      = 4'd0;

        // Reset
        step(1, 0, 0, 8'h00, 0, 0, 0, 4'd1);
        step(1, 0, 0, 8'h00, 0, 0, 0, 4'd1);
        for (int i = 0; i < 16; i++) checkReg(i, 8'h00);

        // Loads
        step(0, 1, 1, 8'd2,        0, 0, 0, 4'd0);
        step(0, 1, 1, 8'd4,        1, 0, 0, 4'd0);
        step(0, 1, 1, 8'd8,        2, 0, 0, 4'd0);
        step(0, 1, 1, 8'd16,       3, 0, 0, 4'd0);
        step(0, 1, 1, 8'b10101010, 4, 0, 0, 4'd0);
        step(0, 1, 1, 8'b11001100, 5, 0, 0, 4'd0);
        checkReg(0, 8'd2);  checkReg(1, 8'd4);  checkReg(2, 8'd8);
        checkReg(3, 8'd16); checkReg(4, 8'hAA); checkReg(5, 8'hCC);

        // ALU write-back
        step(0, 1, 0, 8'h00, 15, 0, 1, 4'd4);   // ADD r0,r1
        checkReg(15, 8'd6);
        step(0, 1, 0, 8'h00, 14, 0, 1, 4'd9);   // GT r0,r1
        checkReg(14, 8'd0);
        step(0, 1, 0, 8'h00, 13, 2, 1, 4'd9);   // GT r2,r1
        checkReg(13, 8'd1);
        step(0, 1, 0, 8'h00, 12, 2, 2, 4'd8);   // EQ r2,r2
        checkReg(12, 8'd1);
        step(0, 1, 0, 8'h00, 11, 2, 0, 4'd5);   // NEG r2
        checkReg(11, 8'd248);
        step(0, 1, 0, 8'h00, 10, 3, 11, 4'd4);  // ADD r3,r11 wraps
        checkReg(10, 8'd8);
        step(0, 1, 0, 8'h00, 8, 4, 5, 4'd6);    // AND
        checkReg(8, 8'b10001000);
        step(0, 1, 0, 8'h00, 7, 4, 5, 4'd7);    // OR
        checkReg(7, 8'b11101110);
        step(0, 1, 1, 8'h5A, 6, 0, 0, 4'd0);    // preload r6 so ZERO is visible
        step(0, 1, 0, 8'h00, 6, 1, 2, 4'd0);    // ZERO
        checkReg(6, 8'd0);

        // Idle cycles: every op observed on aluOut, nothing written
        for (int i = 0; i < 32; i++) begin
            step(0, 0, i[0], 8'($urandom), 4'($urandom), 4'($urandom),
                 4'($urandom), 4'(i));
        end
        step(0, 0, 0, 8'hFF, 4'bxxxx, 4, 5, 4'd12);
        checkAll("idle");
        checkReg(15, 8'd6);
        checkReg(4, 8'hAA);

        // Read-old/write-new on r15
        step(0, 1, 1, 8'd200, 15, 0, 0, 4'd0);
        step(0, 1, 0, 8'h00, 15, 15, 15, 4'd4);
        checkReg(15, 8'd144);

        // Reset during a write: write dropped, everything cleared
        step(1, 1, 1, 8'h55, 3, 4, 5, 4'd7);
        for (int i = 0; i < 16; i++) checkReg(i, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
